color_scan_controller: RTL
==========================

// Module: color_scan_controller
// PURPOSE
//  Sequences a TCS3200-style colour sensor through its four photodiode filters (red, green, blue, clear).
//  Per filter: drives S2/S3, waits a settle time, then counts sensor output edges over a fixed gate window.
//  Then classifies the dominant colour and presents all four counts.
//  Sits between the rover's navigation FSM (start/done handshake) and the sensor pins.
// PARAMETERS
//  GATE_CYCLES   100000  clk cycles per counting window
//  SETTLE_CYCLES 1000    clk cycles after filter change before counting
//  CNT_W         16      width of each channel count; saturates at 2^CNT_W-1
//  MIN_CLEAR     20      clear count below this => color_id NONE
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous active-high reset
//  start        in   1      request one full scan; sampled only in IDLE
//  freq_in      in   1      sensor square-wave output, asynchronous to clk
//  sensor_en    out  1      sensor enable (high while busy)
//  s2, s3       out  1      filter select: R=00 G=11 B=01 C=10
//  busy         out  1      high from cycle after accepted start until done
//  done         out  1      one-cycle pulse: results valid
//  red_cnt      out  CNT_W  latched red edge count
//  green_cnt    out  CNT_W  latched green edge count
//  blue_cnt     out  CNT_W  latched blue edge count
//  clear_cnt    out  CNT_W  latched clear edge count
//  color_id     out  2      0 NONE, 1 RED, 2 GREEN, 3 BLUE; held until next done
// BEHAVIOUR
//  - Reset: state IDLE. sensor_en=0, s2=0, s3=0, busy=0, done=0, all *_cnt=0, color_id=0. Sync/edge flops=0.
//  - freq_in passes through a 2-flop synchroniser. Edge = sync==1 && last==0; last updates every cycle.
//  - FSM states: IDLE, SETTLE, GATE, STORE, CLASSIFY, DONE.
//    - IDLE: start=1 -> SETTLE, channel=RED.
//    - SETTLE: exactly SETTLE_CYCLES cycles -> GATE.
//    - GATE: exactly GATE_CYCLES cycles. Edges count only while in GATE; edge counter clears on GATE entry.
//    - STORE: 1 cycle. Copy the count to that channel's *_cnt register.
//      Channel order R,G,B,C. After C -> CLASSIFY, else next channel -> SETTLE.
//    - CLASSIFY: 1 cycle. If clear_cnt < MIN_CLEAR, color_id=NONE.
//      Otherwise color_id = largest of R/G/B, tie priority G>R>B.
//    - DONE: done=1 for 1 cycle -> IDLE.
//  - Latency: start accepted at cycle 0 -> done high at cycle 4*(SETTLE_CYCLES+GATE_CYCLES+1)+2.
//  - s2/s3 change on SETTLE entry and are stable through GATE and STORE; s2=s3=0 in IDLE.
//  - busy=1 and sensor_en=1 in all states except IDLE. busy drops in the cycle after DONE.
//  - start while busy: ignored, not queued. start held high re-triggers a scan in the IDLE cycle after DONE.
//  - Count saturates at 2^CNT_W-1; no wrap-around.
//  - *_cnt and color_id update only in STORE/CLASSIFY; previous results are visible until overwritten.
//  - rst mid-scan: immediate return to reset values. Partial results are discarded and no done is issued.
// STRUCTURE
//  - Package color_pkg: state enum, channel enum, S2S3 filter codes, color_id codes.
//  - Sub-module edge_counter: synchroniser, edge detect, clear/enable, saturating CNT_W counter.
//  - This module holds the FSM, a cycle timer wide enough for max(SETTLE,GATE), result registers and the classifier.
// TESTING (bench params: GATE=100, SETTLE=10, CNT_W=8, MIN_CLEAR=5)
//  - freq_in period 10 clk for R/B/C, period 4 clk for G
//      -> green_cnt=25, others=10, color_id=2, done at cycle 446.
//  - freq_in stuck 0
//      -> all counts 0, color_id=0, done still issued at cycle 446.
//  - freq_in toggling every clk (CNT_W=5)
//      -> counts saturate at 31, no wrap.
//  - R=G=20, B=5, C=30
//      -> color_id=2 (tie G>R). Repeat with C=4 -> color_id=0.
//  - start pulsed again mid-GATE
//      -> ignored, single done. start held high -> second scan begins the cycle after busy falls.
//  - rst asserted in the BLUE GATE window
//      -> next cycle all outputs at reset values, no done. A fresh scan completes normally.

Source files
------------

// File: rtl/color_pkg.sv
// ============================================================================
//  Module   : color_pkg
//  Brief    : Shared types and codes for the colour-sensor scan controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package color_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_GATE     = 3'd2,
        ST_STORE    = 3'd3,
        ST_CLASSIFY = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2,
        CH_CLEAR = 2'd3
    } channel_t;

    // {S2,S3} photodiode filter selection codes
    localparam logic [1:0] c_FILT_RED   = 2'b00;
    localparam logic [1:0] c_FILT_GREEN = 2'b11;
    localparam logic [1:0] c_FILT_BLUE  = 2'b01;
    localparam logic [1:0] c_FILT_CLEAR = 2'b10;

    localparam logic [1:0] c_COLOR_NONE  = 2'd0;
    localparam logic [1:0] c_COLOR_RED   = 2'd1;
    localparam logic [1:0] c_COLOR_GREEN = 2'd2;
    localparam logic [1:0] c_COLOR_BLUE  = 2'd3;

    function automatic logic [1:0] filter_code(input channel_t ch);
        case (ch)
            CH_RED:   return c_FILT_RED;
            CH_GREEN: return c_FILT_GREEN;
            CH_BLUE:  return c_FILT_BLUE;
            default:  return c_FILT_CLEAR;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_counter.sv
// ============================================================================
//  Module   : edge_counter
//  Brief    : Synchronises an asynchronous square wave and counts its rising
//             edges into a saturating counter with clear and enable.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_freq,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_last;
    logic [CNT_W-1:0] r_count;
    logic             w_edge;

    assign w_edge = r_sync2 & ~r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_sync1 <= i_freq;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
        end
    end

    // Counter sticks at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en && w_edge && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/color_scan_controller.sv
// ============================================================================
//  Module   : color_scan_controller
//  Brief    : Steps a TCS3200-style sensor through R/G/B/C filters, counts
//             edges per filter, and classifies the dominant colour.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module color_scan_controller
    import color_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned MIN_CLEAR     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             freq_in,
    output logic             sensor_en,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [1:0]       color_id
);

    localparam int unsigned c_TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int          c_TMR_W   = $clog2(c_TMR_MAX + 1);

    state_t             r_state;
    state_t             w_next_state;
    channel_t           r_channel;
    logic [c_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_red_cnt;
    logic [CNT_W-1:0]   r_green_cnt;
    logic [CNT_W-1:0]   r_blue_cnt;
    logic [CNT_W-1:0]   r_clear_cnt;
    logic [1:0]         r_color;

    logic               w_settle_last;
    logic               w_gate_last;
    logic               w_cnt_clear;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_count;
    logic [1:0]         w_color;
    logic [1:0]         w_filter;

    assign w_settle_last = (r_timer == c_TMR_W'(SETTLE_CYCLES - 1));
    assign w_gate_last   = (r_timer == c_TMR_W'(GATE_CYCLES - 1));
    // Counter is zeroed on the last settle cycle so it starts clean in GATE
    assign w_cnt_clear   = (r_state == ST_SETTLE) && w_settle_last;
    assign w_cnt_en      = (r_state == ST_GATE);

    edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk     (clk),
        .rst     (rst),
        .i_freq  (freq_in),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next_state = ST_SETTLE;
            ST_SETTLE:   if (w_settle_last) w_next_state = ST_GATE;
            ST_GATE:     if (w_gate_last) w_next_state = ST_STORE;
            ST_STORE:    w_next_state = (r_channel == CH_CLEAR) ? ST_CLASSIFY : ST_SETTLE;
            ST_CLASSIFY: w_next_state = ST_DONE;
            ST_DONE:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_channel <= CH_RED;
            r_timer   <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= (w_next_state != r_state) ? '0 : r_timer + 1'b1;
            if (r_state == ST_IDLE && start) begin
                r_channel <= CH_RED;
            end else if (r_state == ST_STORE && r_channel != CH_CLEAR) begin
                r_channel <= channel_t'(r_channel + 2'd1);
            end
        end
    end

    // Tie priority: green beats red beats blue
    always_comb begin
        w_color = c_COLOR_NONE;
        if (32'(r_clear_cnt) >= MIN_CLEAR) begin
            if (r_green_cnt >= r_red_cnt && r_green_cnt >= r_blue_cnt) begin
                w_color = c_COLOR_GREEN;
            end else if (r_red_cnt >= r_blue_cnt) begin
                w_color = c_COLOR_RED;
            end else begin
                w_color = c_COLOR_BLUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red_cnt   <= '0;
            r_green_cnt <= '0;
            r_blue_cnt  <= '0;
            r_clear_cnt <= '0;
            r_color     <= c_COLOR_NONE;
        end else if (r_state == ST_STORE) begin
            case (r_channel)
                CH_RED:   r_red_cnt   <= w_count;
                CH_GREEN: r_green_cnt <= w_count;
                CH_BLUE:  r_blue_cnt  <= w_count;
                default:  r_clear_cnt <= w_count;
            endcase
        end else if (r_state == ST_CLASSIFY) begin
            r_color <= w_color;
        end
    end

    assign w_filter  = (r_state == ST_IDLE) ? 2'b00 : filter_code(r_channel);
    assign s2        = w_filter[1];
    assign s3        = w_filter[0];
    assign busy      = (r_state != ST_IDLE);
    assign sensor_en = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign red_cnt   = r_red_cnt;
    assign green_cnt = r_green_cnt;
    assign blue_cnt  = r_blue_cnt;
    assign clear_cnt = r_clear_cnt;
    assign color_id  = r_color;

endmodule

`default_nettype wire
